mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sequences the single shared word-wide memory port between the instruction cache (IC, refill only) and the data cache (DC, refill or dirty-line write-back).
- Grants one line burst at a time, generates word addresses, and captures the write-back line at grant.
- Returns refill words to the owning cache with word index and a done pulse.
- Sits between both caches and the memory model.

Parameters:
- BURST_LEN, 8, words per cache line; power of two, at least 2; line = 32*BURST_LEN bits.
- CNT_W, 3, word counter width, equal to log2(BURST_LEN).

Ports:
- clk  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-high reset.
- ic_req  in  1  IC requests a line refill; held until ic_done.
- ic_addr  in  32  IC miss address; low CNT_W+2 bits ignored.
- ic_grant  out  1  high while the IC owns the port.
- ic_rvalid  out  1  one-cycle pulse: ic_rdata/ic_rword valid.
- ic_rdata  out  32  refill word.
- ic_rword  out  CNT_W  index of the refill word within the line.
- ic_done  out  1  one-cycle pulse: burst complete.
- dc_req  in  1  DC request; held until dc_done.
- dc_is_wb  in  1  1 = write-back of dc_wb_data to dc_addr; 0 = refill.
- dc_addr  in  32  DC line address; low CNT_W+2 bits ignored.
- dc_wb_data  in  32*BURST_LEN  dirty line; word i is bits [32i+:32].
- dc_grant, dc_rvalid, dc_rdata, dc_rword, dc_done  out  same widths and meaning as the IC equivalents.
- mem_req  out  1  memory transfer request, one word.
- mem_we  out  1  1 = write mem_wdata; 0 = read.
- mem_addr  out  32  word address {line[31:CNT_W+2], cnt, 2'b00}.
- mem_wdata  out  32  write word.
- mem_ack  in  1  word accepted (write) or mem_rdata valid (read), same cycle.
- mem_rdata  in  32  read word.

Behaviour:
- Reset: every output 0; state IDLE; cnt 0; rr_last 0 (DC granted last); captured line and address registers 0.
- A reset mid-burst aborts the burst immediately. No done pulse is issued; the requesting cache re-requests.
- States:
  - IDLE: sample ic_req and dc_req at posedge.
    - Neither asserted: stay in IDLE.
    - One asserted: grant it.
    - Both asserted: round-robin; grant the requester not equal to rr_last.
  - On grant:
    - Latch the line address (and dc_wb_data if this is a write-back).
    - Set rr_last to the winner and cnt to 0.
    - Go to IC_RD, DC_RD or DC_WB. The grant goes high in the first cycle of that state, one cycle after the request is sampled.
  - IC_RD / DC_RD:
    - mem_req=1, mem_we=0, mem_addr from the latched line address and cnt.
    - Each mem_ack: the next cycle asserts the owner's rvalid with rdata=mem_rdata and rword=cnt; cnt increments.
  - DC_WB:
    - mem_req=1, mem_we=1, mem_wdata = captured word cnt.
    - Each mem_ack increments cnt.
  - Last burst word:
    - Acked when cnt==BURST_LEN-1. That ack moves to DONE; cnt wraps to 0.
    - In DONE: grant is low, the owner's done pulses for one cycle, and for reads the final rvalid pulses in the same cycle.
  - DONE → IDLE unconditionally. Requests are not sampled in DONE, so a requester deasserting req in the cycle after done is never re-granted.
- Back-to-back requests: minimum gap between bursts is 2 cycles (DONE, IDLE).
- A dirty DC miss issues a WB burst followed by an RD burst. If IC is pending, it is granted between them (round-robin).
- mem_ack with mem_req low is ignored. mem_req stays high until the ack; there is no timeout.
- Requests change only in IDLE sampling. A request dropped mid-burst does not abort the burst.
- The two grants are never high together; mem_req=1 implies exactly one grant is high.

Optional Feature:
- Macro: ARB_STATS_EN. The three counter outputs below exist in both builds.
- Defined:
  - ic_bursts (16-bit out) counts completed IC bursts.
  - dc_bursts (16-bit out) counts completed DC bursts.
  - wait_cycles (16-bit out) counts cycles in which any request was pending but not granted.
  - All three saturate at 16'hFFFF and clear on reset.
- Undefined: all three outputs are tied to 0 and no counter logic is built.

Test Plan:
- IC alone, ic_addr=32'h0000_1234, mem_ack every cycle, mem_rdata=32'hA0+i:
  - mem_addr sequence is 0x1220,0x1224,…,0x123C.
  - ic_rvalid fires 8 times with rword 0..7 and rdata A0..A7.
  - ic_done comes 1 cycle after the 8th ack; grant spans 8 cycles.
- DC write-back, dc_addr=32'h0000_4000, dc_wb_data word i=32'hD0+i:
  - mem_we=1, mem_wdata D0..D7 at 0x4000..0x401C.
  - dc_done after the 8th ack; dc_rvalid never asserts.
- ic_req and dc_req raised together, held, re-raised after each done, from reset:
  - Grants alternate IC, DC, IC, DC (rr_last reset 0 means IC wins first).
  - Never both grants high.
- mem_ack asserted only every 3rd cycle during an IC refill:
  - mem_addr holds until each ack; exactly 8 rvalids; cnt never skips.
- reset pulsed during word 4 of a DC refill:
  - All outputs 0 asynchronously; no dc_done.
  - A new dc_req afterwards restarts at word 0.
- With ARB_STATS_EN, run the contention test for 4 bursts:
  - ic_bursts=2, dc_bursts=2, wait_cycles equal to the bench-counted value.
  - Without the macro, all three read 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one word-wide memory port between the instruction
// cache (refill only) and the data cache (refill or dirty-line write-back).
// One line burst is granted at a time. Round-robin decides between
// simultaneous requests. Refill words return to the owner with their word
// index, followed by a done pulse.
//
// Build option: define ARB_STATS_EN to build the burst and wait-cycle
// counters. Without it, ic_bursts/dc_bursts/wait_cycles read as zero.
//
// Handshake: mem_req stays high, with mem_addr/mem_we/mem_wdata stable, until
// a cycle in which mem_ack is also high. That cycle transfers one word. For a
// read, mem_rdata is valid in the same cycle. mem_ack is ignored while mem_req
// is low. Cache requests are level signals that are held until done. They are
// only sampled in IDLE.
//
// The FSM state is the enum signal 'state' (IDLE, IC_RD, DC_RD, DC_WB, DONE),
// so checkers can probe it hierarchically.
module mem_port_arbiter #(
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ic_req,
    input  logic [31:0]             ic_addr,
    output logic                    ic_grant,
    output logic                    ic_rvalid,
    output logic [31:0]             ic_rdata,
    output logic [CNT_W-1:0]        ic_rword,
    output logic                    ic_done,
    input  logic                    dc_req,
    input  logic                    dc_is_wb,
    input  logic [31:0]             dc_addr,
    input  logic [32*BURST_LEN-1:0] dc_wb_data,
    output logic                    dc_grant,
    output logic                    dc_rvalid,
    output logic [31:0]             dc_rdata,
    output logic [CNT_W-1:0]        dc_rword,
    output logic                    dc_done,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_ack,
    input  logic [31:0]             mem_rdata,
    output logic [15:0]             ic_bursts,
    output logic [15:0]             dc_bursts,
    output logic [15:0]             wait_cycles
);

    localparam int LINE_W = 32 * BURST_LEN;
    localparam int OFF_W  = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IC_RD = 3'd1,
        ST_DC_RD = 3'd2,
        ST_DC_WB = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]    cnt;
    logic                rr_last;    // 1 = IC owned the last burst, 0 = DC
    logic [31-OFF_W:0]   line_addr;
    logic [LINE_W-1:0]   wb_line;
    logic                rvalid_q;
    logic [31:0]         rdata_q;
    logic [CNT_W-1:0]    rword_q;

    logic                pick_ic;
    logic                pick_dc;
    logic                grant_now;
    logic                busy;
    logic                word_ack;
    logic                last_ack;

    // The offset bits of the request addresses carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ic_addr[OFF_W-1:0], dc_addr[OFF_W-1:0]};

    // Round-robin: on a tie, the requester that did not own the last burst wins.
    assign pick_ic   = ic_req && (!dc_req || !rr_last);
    assign pick_dc   = dc_req && !pick_ic;
    assign grant_now = (state == ST_IDLE) && (pick_ic || pick_dc);

    assign busy      = (state == ST_IC_RD) || (state == ST_DC_RD) || (state == ST_DC_WB);
    assign word_ack  = busy && mem_ack;
    assign last_ack  = word_ack && (cnt == LAST_WORD);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: IDLE arbitrates, bursts run to the last ack, DONE lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pick_ic)      state_nxt = ST_IC_RD;
                else if (pick_dc) state_nxt = dc_is_wb ? ST_DC_WB : ST_DC_RD;
            end
            ST_IC_RD, ST_DC_RD, ST_DC_WB: begin
                if (last_ack) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winner, its line address and, for a write-back, the dirty line at grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last   <= 1'b0;
            line_addr <= '0;
            wb_line   <= '0;
        end else if (grant_now) begin
            rr_last   <= pick_ic;
            line_addr <= pick_ic ? ic_addr[31:OFF_W] : dc_addr[31:OFF_W];
            if (pick_dc && dc_is_wb) wb_line <= dc_wb_data;
        end
    end

    // Word counter: cleared at grant, advanced by every accepted word, wraps on the last
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          cnt <= '0;
        else if (grant_now) cnt <= '0;
        else if (word_ack)  cnt <= cnt + 1'b1;
    end

    // Register each read word for a one-cycle return pulse to the owner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rword_q  <= '0;
        end else begin
            rvalid_q <= word_ack && (state != ST_DC_WB);
            if (word_ack && (state != ST_DC_WB)) begin
                rdata_q <= mem_rdata;
                rword_q <= cnt;
            end
        end
    end

    // Outputs decoded from state; the owner of the current or just-finished burst is rr_last
    always_comb begin
        ic_grant  = (state == ST_IC_RD);
        dc_grant  = (state == ST_DC_RD) || (state == ST_DC_WB);
        mem_req   = busy;
        mem_we    = (state == ST_DC_WB);
        mem_addr  = busy ? {line_addr, cnt, 2'b00} : 32'd0;
        mem_wdata = (state == ST_DC_WB) ? wb_line[{cnt, 5'd0} +: 32] : 32'd0;
        ic_rvalid = rvalid_q && rr_last;
        dc_rvalid = rvalid_q && !rr_last;
        ic_rdata  = ic_rvalid ? rdata_q : 32'd0;
        dc_rdata  = dc_rvalid ? rdata_q : 32'd0;
        ic_rword  = ic_rvalid ? rword_q : '0;
        dc_rword  = dc_rvalid ? rword_q : '0;
        ic_done   = (state == ST_DONE) && rr_last;
        dc_done   = (state == ST_DONE) && !rr_last;
    end

`ifdef ARB_STATS_EN
    logic any_waiting;
    assign any_waiting = (ic_req && !ic_grant) || (dc_req && !dc_grant);

    // Saturating activity counters: completed bursts per cache and cycles spent waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ic_bursts   <= '0;
            dc_bursts   <= '0;
            wait_cycles <= '0;
        end else begin
            if (ic_done && (ic_bursts != 16'hFFFF))       ic_bursts   <= ic_bursts + 16'd1;
            if (dc_done && (dc_bursts != 16'hFFFF))       dc_bursts   <= dc_bursts + 16'd1;
            if (any_waiting && (wait_cycles != 16'hFFFF)) wait_cycles <= wait_cycles + 16'd1;
        end
    end
`else
    assign ic_bursts   = 16'd0;
    assign dc_bursts   = 16'd0;
    assign wait_cycles = 16'd0;
`endif

endmodule
